// File: rtl/common_fifo_ptr_wrap.sv
// Wrap-at-DEPTH-1 pointer register for the DFF-RAM FIFO controller.
// Reset dominates the synchronous clear, which dominates the increment.
module common_fifo_ptr_wrap #(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [PW-1:0] ptr_nxt;

   // explicit compare so non-power-of-two depths wrap correctly
   always_comb begin
      ptr_nxt = ptr + PW'(1);
      if (ptr == LAST) begin
         ptr_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/common_dffram_fifo_ctrl.sv
// FWFT FIFO controller in front of a 1W/1R-comb DFF RAM; holds no storage.
// Optional macro COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN enables empty pass-through.
module common_dffram_fifo_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_WIDTH = 8,
   localparam int PTR_WIDTH = $clog2(FIFO_DEPTH),
   localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  count,
   output logic [PTR_WIDTH-1:0]  ram_addra,
   output logic                  ram_ena,
   output logic                  ram_wea,
   output logic [DATA_WIDTH-1:0] ram_dina,
   output logic [PTR_WIDTH-1:0]  ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_doutb
);

   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(FIFO_DEPTH);

   logic empty;
   logic push;
   logic pop;
   logic bypass;
   logic wr_inc;
   logic rd_inc;
   logic [PTR_WIDTH-1:0] wptr;
   logic [PTR_WIDTH-1:0] rptr;

   assign empty    = (count == '0);
   assign in_ready = (count != FULL);

`ifdef COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN
   assign bypass    = empty & in_valid & out_ready;
   assign out_valid = ~empty | in_valid;
   assign out_data  = empty ? in_data : ram_doutb;
`else
   assign bypass    = 1'b0;
   assign out_valid = ~empty;
   assign out_data  = ram_doutb;
`endif

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // a pass-through word never touches storage or state
   assign wr_inc = push & ~bypass & ~flush;
   assign rd_inc = pop & ~bypass & ~flush;

   assign ram_addra = wptr;
   assign ram_addrb = rptr;
   assign ram_ena   = wr_inc;
   assign ram_wea   = 1'b1;
   assign ram_dina  = in_data;

   common_fifo_ptr_wrap #(
      .DEPTH (FIFO_DEPTH)
   ) u_wptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (wr_inc),
      .ptr   (wptr)
   );

   common_fifo_ptr_wrap #(
      .DEPTH (FIFO_DEPTH)
   ) u_rptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (rd_inc),
      .ptr   (rptr)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (wr_inc & ~rd_inc) begin
         count <= count + CNT_WIDTH'(1);
      end else if (rd_inc & ~wr_inc) begin
         count <= count - CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_common_dffram_fifo_ctrl.sv
// Bench: depth-4 and depth-3 controllers with RAM models, queue-based model.
// Shared directed stimulus; every-cycle compare plus literal checks.
module tb_common_dffram_fifo_ctrl;

`ifdef COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_data = '0;

   logic       iry_a, ov_a, ena_a, wea_a;
   logic [7:0] od_a, din_a, dout_a;
   logic [2:0] cnt_a;
   logic [1:0] aa_a, ab_a;
   logic [7:0] mem_a [4];

   logic       iry_b, ov_b, ena_b, wea_b;
   logic [7:0] od_b, din_b, dout_b;
   logic [1:0] cnt_b;
   logic [1:0] aa_b, ab_b;
   logic [7:0] mem_b [4];

   int n_tests = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   assign dout_a = mem_a[ab_a];
   assign dout_b = mem_b[ab_b];

   always @(posedge clk) if (ena_a && wea_a) mem_a[aa_a] <= din_a;
   always @(posedge clk) if (ena_b && wea_b) mem_b[aa_b] <= din_b;

   common_dffram_fifo_ctrl #(.FIFO_DEPTH(4), .DATA_WIDTH(8)) u_a (
      .clk (clk), .reset (reset), .flush (flush),
      .in_valid (in_valid), .in_ready (iry_a), .in_data (in_data),
      .out_valid (ov_a), .out_ready (out_ready), .out_data (od_a),
      .count (cnt_a), .ram_addra (aa_a), .ram_ena (ena_a),
      .ram_wea (wea_a), .ram_dina (din_a), .ram_addrb (ab_a),
      .ram_doutb (dout_a)
   );

   common_dffram_fifo_ctrl #(.FIFO_DEPTH(3), .DATA_WIDTH(8)) u_b (
      .clk (clk), .reset (reset), .flush (flush),
      .in_valid (in_valid), .in_ready (iry_b), .in_data (in_data),
      .out_valid (ov_b), .out_ready (out_ready), .out_data (od_b),
      .count (cnt_b), .ram_addra (aa_b), .ram_ena (ena_b),
      .ram_wea (wea_b), .ram_dina (din_b), .ram_addrb (ab_b),
      .ram_doutb (dout_b)
   );

   task automatic lit(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   // model: contents queue, pointers as push/pop totals mod depth
   logic [7:0] q [2][$];
   int wp [2] = '{0, 0};
   int rp [2] = '{0, 0};
   int dep [2] = '{4, 3};

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int  sz;
         bit  byp, pu, po;
         sz = q[k].size();
         if (!reset || flush) begin
            q[k].delete();
            wp[k] = 0;
            rp[k] = 0;
         end else begin
            byp = BYP && sz == 0 && in_valid && out_ready;
            pu = in_valid && sz != dep[k] && !byp;
            po = out_ready && sz != 0;
            if (po) begin
               void'(q[k].pop_front());
               rp[k] = (rp[k] + 1) % dep[k];
            end
            if (pu) begin
               q[k].push_back(in_data);
               wp[k] = (wp[k] + 1) % dep[k];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            int  sz;
            bit  byp, e_ov;
            logic [7:0] e_od;
            sz = q[k].size();
            byp = BYP && sz == 0 && in_valid && out_ready;
            e_ov = sz != 0 || (BYP && in_valid);
            e_od = (sz != 0) ? q[k][0] : in_data;
            lit($sformatf("cnt%0d", k),
                k == 0 ? 32'(cnt_a) : 32'(cnt_b), 32'(sz));
            lit($sformatf("in_ready%0d", k),
                k == 0 ? 32'(iry_a) : 32'(iry_b), 32'(sz != dep[k]));
            lit($sformatf("out_valid%0d", k),
                k == 0 ? 32'(ov_a) : 32'(ov_b), 32'(e_ov));
            lit($sformatf("ram_ena%0d", k),
                k == 0 ? 32'(ena_a) : 32'(ena_b),
                32'(in_valid && sz != dep[k] && !flush && !byp));
            lit($sformatf("addra%0d", k),
                k == 0 ? 32'(aa_a) : 32'(aa_b), 32'(wp[k]));
            lit($sformatf("addrb%0d", k),
                k == 0 ? 32'(ab_a) : 32'(ab_b), 32'(rp[k]));
            lit($sformatf("wea%0d", k),
                k == 0 ? 32'(wea_a) : 32'(wea_b), 32'd1);
            if (e_ov) begin
               lit($sformatf("out_data%0d", k),
                   k == 0 ? 32'(od_a) : 32'(od_b), 32'(e_od));
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic [7:0] d,
                      input logic r, input logic f);
      @(posedge clk);
      #1;
      in_valid = v;
      in_data = d;
      out_ready = r;
      flush = f;
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      reset = 1'b1;
      #1;
      lit("rst_cnt", 32'(cnt_a), 32'd0);
      lit("rst_ready", 32'(iry_a), 32'd1);
      lit("rst_ov", 32'(ov_a), 32'd0);
      lit("rst_ena", 32'(ena_a), 32'd0);
      lit("rst_addra", 32'(aa_a), 32'd0);
      lit("rst_addrb", 32'(ab_a), 32'd0);

      // fill and drain
      cyc(1'b1, 8'h11, 1'b0, 1'b0);
      lit("fill_a0", 32'(aa_a), 32'd0);
      cyc(1'b1, 8'h22, 1'b0, 1'b0);
      lit("fill_a1", 32'(aa_a), 32'd1);
      cyc(1'b1, 8'h33, 1'b0, 1'b0);
      lit("fill_a2", 32'(aa_a), 32'd2);
      cyc(1'b1, 8'h44, 1'b0, 1'b0);
      lit("fill_a3", 32'(aa_a), 32'd3);
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      lit("full_cnt", 32'(cnt_a), 32'd4);
      lit("full_ready", 32'(iry_a), 32'd0);
      lit("full_ena", 32'(ena_a), 32'd0);
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      lit("full_pop_head", 32'(od_a), 32'h11);
      lit("full_pop_ena", 32'(ena_a), 32'd0);
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      lit("after_pop_cnt", 32'(cnt_a), 32'd3);
      lit("after_pop_head", 32'(od_a), 32'h22);
      lit("held_push_ena", 32'(ena_a), 32'd1);
      for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      lit("drained_ov", 32'(ov_a), 32'd0);

      // wrap on the depth-3 instance
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 8'(i + 1), 1'b1, 1'b0);
`ifndef COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN
         lit($sformatf("wrap_addra_%0d", i), 32'(aa_b), 32'(i % 3));
         if (i >= 1) begin
            lit($sformatf("wrap_addrb_%0d", i), 32'(ab_b),
                32'((i - 1) % 3));
         end
`endif
      end
      repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // simultaneous push/pop
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'hA1, 1'b0, 1'b0);
      cyc(1'b1, 8'hA2, 1'b0, 1'b0);
      cyc(1'b1, 8'hA3, 1'b1, 1'b0);
      lit("pp_cnt_before", 32'(cnt_a), 32'd2);
      cyc(1'b1, 8'hA4, 1'b0, 1'b0);
      lit("pp_cnt_hold", 32'(cnt_a), 32'd2);
      lit("pp_addra", 32'(aa_a), 32'd3);
      lit("pp_addrb", 32'(ab_a), 32'd1);
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      cyc(1'b1, 8'hA6, 1'b1, 1'b0);
      lit("pp_full_cnt", 32'(cnt_a), 32'd4);
      lit("pp_full_ena", 32'(ena_a), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      lit("pp_full_after", 32'(cnt_a), 32'd3);
      lit("pp_wrap_addra", 32'(aa_a), 32'd1);

      // flush overrides push and pop
      cyc(1'b1, 8'hB1, 1'b1, 1'b1);
      lit("flush_ena_a", 32'(ena_a), 32'd0);
      lit("flush_ena_b", 32'(ena_b), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      lit("flush_cnt", 32'(cnt_a), 32'd0);
      lit("flush_addra", 32'(aa_a), 32'd0);
      lit("flush_addrb", 32'(ab_a), 32'd0);
      lit("flush_ov", 32'(ov_a), 32'd0);

      // empty push with consumer ready
      cyc(1'b1, 8'hA5, 1'b1, 1'b0);
`ifdef COMMON_DFFRAM_FIFO_CTRL_BYPASS_EN
      lit("byp_ov", 32'(ov_a), 32'd1);
      lit("byp_od", 32'(od_a), 32'hA5);
      lit("byp_ena", 32'(ena_a), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      lit("byp_cnt", 32'(cnt_a), 32'd0);
      lit("byp_ov_after", 32'(ov_a), 32'd0);
`else
      lit("nobyp_ov", 32'(ov_a), 32'd0);
      lit("nobyp_ena", 32'(ena_a), 32'd1);
      lit("nobyp_addra", 32'(aa_a), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      lit("nobyp_ov_next", 32'(ov_a), 32'd1);
      lit("nobyp_od_next", 32'(od_a), 32'hA5);
      lit("nobyp_cnt", 32'(cnt_a), 32'd1);
`endif

      // reset mid-stream
      cyc(1'b1, 8'hC1, 1'b0, 1'b0);
      cyc(1'b1, 8'hC2, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      cyc(1'b1, 8'h77, 1'b0, 1'b0);
      reset = 1'b1;
      lit("mid_rst_cnt", 32'(cnt_a), 32'd0);
      lit("mid_rst_ena", 32'(ena_a), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      lit("mid_rst_cnt1", 32'(cnt_a), 32'd1);
      lit("mid_rst_head", 32'(od_a), 32'h77);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      lit("mid_rst_empty", 32'(ov_a), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
